floo_rsp_shuffler: RTL and testbench
====================================

Name: floo_rsp_shuffler

Overview:
- Synthesizable response-side stress block: buffers ID-tagged response beats (AXI B or single-beat R) on a valid/ready stream and releases them in pseudo-random order.
- Preserves ordering among beats with the same ID, as AXI requires.
- Placed between a chimney's axi_out response path and a slave model. It is the responder-end counterpart of the chimney reorder buffer: it generates the out-of-order traffic that the reorder buffer must resolve.

Parameters:
- Depth, 8, number of buffer entries (power of two, >=2)
- IdWidth, 4, width of response ID
- DataWidth, 32, width of opaque payload carried with each beat
- MaxHold, 16, cycles a non-full, non-empty buffer may hold entries before release is forced
- LfsrSeed, 16'hACE1, reset value of the 16-bit selection LFSR (must be non-zero)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  1 = shuffle; 0 = pass-through FIFO order, no holding
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat ready
- id_i  in  IdWidth  input beat ID
- data_i  in  DataWidth  input beat payload
- valid_o  out  1  output beat valid
- ready_i  in  1  output beat ready
- id_o  out  IdWidth  output beat ID
- data_o  out  DataWidth  output beat payload
- occupancy_o  out  $clog2(Depth)+1  number of valid entries

Behaviour:
- Single clock domain clk_i. rst_i is synchronous, active-high. During reset and on the first cycle after it: all entries invalid, occupancy_o=0, valid_o=0, hold counter=0, LFSR=LfsrSeed, no selection locked.
- ready_o = !full && !rst_i. It is combinational from registered state only; there is no path from ready_i.
- Write: on valid_i&&ready_o, the beat goes into the lowest-index free entry and becomes younger than every resident entry. Minimum latency is 1 cycle: a beat accepted in cycle N can appear on valid_o no earlier than N+1.
- Age tracking: an age matrix (or equivalent) records, for each valid pair (i,j), whether i is older than j.
  - An entry is eligible if no older valid entry has the same ID.
  - The oldest entry overall is always eligible.
- Release armed when any of:
  - en_i=0
  - occupancy==Depth
  - hold counter >= MaxHold
- Hold counter:
  - increments each cycle while occupancy>0 and no output handshake occurs
  - clears on an output handshake and when occupancy is 0
  - saturates at MaxHold
- Selection, when armed and no selection is locked:
  - en_i=1: start at index lfsr[$clog2(Depth)-1:0], scan upward with wrap, pick the first eligible entry.
  - en_i=0: pick the oldest entry.
  - The picked index is locked; valid_o rises the next cycle.
- Locked selection:
  - While valid_o&&!ready_i, id_o and data_o are held stable and the lock is not changed, even if en_i toggles.
  - On valid_o&&ready_i: the entry is freed, ages are updated, the lock is cleared, and valid_o falls unless a new selection was locked in the same cycle (back-to-back release allowed).
- id_o and data_o are undefined (drive '0) while valid_o=0.
- LFSR: Fibonacci, taps 16,14,13,11; advances every cycle out of reset.
- Simultaneous write and release in one cycle is allowed. If the buffer is full, ready_o=0 that cycle; the freed slot is writable the next cycle.
- A write may not overwrite the locked entry. Free-slot selection excludes valid entries by construction.
- Reset mid-operation discards all resident entries with no output.

Optional Feature:
- Macro: FLOO_RSP_SHUFFLER_STATS_EN.
- When defined:
  - adds output port num_reordered_o (32 bits, reset 0)
  - increments by 1 on each output handshake where the released entry was not the oldest overall
  - saturates at 32'hFFFF_FFFF
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- en_i=0, ready_i=1: push id 0..7, data 'h10..'h17 back-to-back -> output in identical order, each beat 1 cycle after its acceptance, occupancy_o never exceeds 1.
- en_i=1, ready_i=1, Depth=8: push 8 beats with distinct ids 0..7 -> no valid_o before occupancy_o=8; valid_o rises the cycle after full; all 8 data values out exactly once in an order different from input (for LfsrSeed 'hACE1).
- en_i=1: push 8 beats all id=3, data 0..7 -> output data strictly 0,1,...,7.
- en_i=1, MaxHold=16: push a single beat (id=5, data='hAB) then idle -> valid_o rises exactly 17 cycles after the acceptance edge, with id_o=5, data_o='hAB.
- en_i=1: fill to 8, hold ready_i=0 for 10 cycles -> id_o/data_o stable throughout, ready_o=0; after ready_i=1 all 8 beats drain with none lost or duplicated.
- With 5 entries resident, pulse rst_i for 1 cycle -> next cycle occupancy_o=0, valid_o=0, ready_o=1; no resident beat ever appears on the output.

Source files
------------

// File: rtl/floo_rsp_shuffler.sv
// rtl/floo_rsp_shuffler.sv - ID-order-preserving pseudo-random response reorderer.
// Optional FLOO_RSP_SHUFFLER_STATS_EN adds num_reordered_o.
module floo_rsp_shuffler #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxHold   = 16,
    parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [IdWidth-1:0]         id_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [IdWidth-1:0]         id_o,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth):0]     occupancy_o
`ifdef FLOO_RSP_SHUFFLER_STATS_EN
    ,
    output logic [31:0]                num_reordered_o
`endif
);
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam int unsigned OccW  = IdxW + 1;
    localparam int unsigned HoldW = $clog2(MaxHold + 1);

    logic [Depth-1:0]                valid_q, valid_d;
    logic [Depth-1:0][Depth-1:0]     older_q, older_d;
    logic [Depth-1:0][IdWidth-1:0]   id_q, id_d;
    logic [Depth-1:0][DataWidth-1:0] data_q, data_d;
    logic [HoldW-1:0]                hold_q, hold_d;
    logic [15:0]                     lfsr_q, lfsr_d;
    logic                            lock_vld_q, lock_vld_d;
    logic [IdxW-1:0]                 lock_idx_q, lock_idx_d;

    logic [OccW-1:0] occ;
    logic            full, push, pop, armed, free_found, sel_found;
    logic [IdxW-1:0] free_idx, sel_idx, scan_idx;
    logic [Depth-1:0] elig, oldest;

    always_comb begin
        occ = '0;
        for (int i = 0; i < Depth; i++) occ = occ + OccW'(valid_q[i]);
        full       = (occ == OccW'(Depth));
        ready_o    = !full && !rst_i;
        push       = valid_i && ready_o;
        pop        = lock_vld_q && ready_i;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IdxW'(i);
                free_found = 1'b1;
            end
        end
    end

    // Selection runs on the post-release, post-write state so a beat can leave the cycle after entry.
    always_comb begin
        valid_d = valid_q;
        older_d = older_q;
        id_d    = id_q;
        data_d  = data_q;
        if (pop) valid_d[lock_idx_q] = 1'b0;
        if (push) begin
            for (int j = 0; j < Depth; j++) older_d[j][free_idx] = valid_d[j];
            for (int j = 0; j < Depth; j++) older_d[free_idx][j] = 1'b0;
            valid_d[free_idx] = 1'b1;
            id_d[free_idx]    = id_i;
            data_d[free_idx]  = data_i;
        end

        for (int i = 0; i < Depth; i++) begin
            elig[i]   = valid_d[i];
            oldest[i] = valid_d[i];
            for (int j = 0; j < Depth; j++) begin
                if (valid_d[j] && older_d[j][i]) begin
                    oldest[i] = 1'b0;
                    if (id_d[j] == id_d[i]) elig[i] = 1'b0;
                end
            end
        end

        armed     = !en_i || full || (hold_q >= HoldW'(MaxHold));
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < Depth; k++) begin
            scan_idx = en_i ? lfsr_q[IdxW-1:0] + IdxW'(k) : IdxW'(k);
            if (!sel_found && (en_i ? elig[scan_idx] : oldest[scan_idx])) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end

        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (pop) lock_vld_d = 1'b0;
        if (armed && (!lock_vld_q || pop) && sel_found) begin
            lock_vld_d = 1'b1;
            lock_idx_d = sel_idx;
        end

        if (pop || occ == '0)                hold_d = '0;
        else if (hold_q < HoldW'(MaxHold))   hold_d = hold_q + HoldW'(1);
        else                                 hold_d = hold_q;

        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            older_q    <= '0;
            id_q       <= '0;
            data_q     <= '0;
            hold_q     <= '0;
            lfsr_q     <= LfsrSeed;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            older_q    <= older_d;
            id_q       <= id_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            lfsr_q     <= lfsr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign valid_o     = lock_vld_q;
    assign id_o        = lock_vld_q ? id_q[lock_idx_q] : '0;
    assign data_o      = lock_vld_q ? data_q[lock_idx_q] : '0;
    assign occupancy_o = occ;

`ifdef FLOO_RSP_SHUFFLER_STATS_EN
    logic [31:0] num_reordered_q, num_reordered_d;
    logic        lock_is_oldest;

    always_comb begin
        lock_is_oldest = 1'b1;
        for (int j = 0; j < Depth; j++) begin
            if (valid_q[j] && older_q[j][lock_idx_q]) lock_is_oldest = 1'b0;
        end
        num_reordered_d = num_reordered_q;
        if (pop && !lock_is_oldest && num_reordered_q != 32'hFFFF_FFFF)
            num_reordered_d = num_reordered_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) num_reordered_q <= '0;
        else       num_reordered_q <= num_reordered_d;
    end

    assign num_reordered_o = num_reordered_q;
`endif
endmodule

// File: tb/tb_floo_rsp_shuffler.sv
// tb/tb_floo_rsp_shuffler.sv - directed self-checking bench for floo_rsp_shuffler.
module tb_floo_rsp_shuffler;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  id_i;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  id_o;
    logic [31:0] data_o;
    logic [3:0]  occ;
`ifdef FLOO_RSP_SHUFFLER_STATS_EN
    logic [31:0] num_reordered;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    floo_rsp_shuffler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .id_i        (id_i),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .id_o        (id_o),
        .data_o      (data_o),
        .occupancy_o (occ)
`ifdef FLOO_RSP_SHUFFLER_STATS_EN
        ,
        .num_reordered_o (num_reordered)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drain with ready_i high; each sampled valid_o cycle is one handshake at the next edge.
    task automatic collect(output logic [31:0] got[8], output int n);
        n = 0;
        for (int c = 0; c < 400 && n < 8; c++) begin
            if (valid_o) begin
                got[n] = data_o;
                n++;
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] got[8];
        logic [31:0] held_data;
        logic [3:0]  held_id;
        logic [7:0]  seen;
        int          n;
        int          first;
        logic        in_order;
        logic        leaked;

        rst = 1'b1; en = 1'b0; valid_i = 1'b0; ready_i = 1'b1; id_i = '0; data_i = '0;
        step(); step();
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_o", 32'(ready_o), 32'd1);

        // Pass-through: each beat visible the cycle after acceptance.
        for (int k = 0; k < 8; k++) begin
            valid_i = 1'b1; id_i = 4'(k); data_i = 32'h10 + 32'(k);
            step();
            chk("pt_valid", 32'(valid_o), 32'd1);
            chk("pt_id", 32'(id_o), 32'(k));
            chk("pt_data", data_o, 32'h10 + 32'(k));
            chk("pt_occ", 32'(occ), 32'd1);
        end
        valid_i = 1'b0;
        step();
        chk("pt_end_valid", 32'(valid_o), 32'd0);
        chk("pt_end_occ", 32'(occ), 32'd0);

        // Shuffle, distinct IDs.
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            valid_i = 1'b1; id_i = 4'(k); data_i = 32'h20 + 32'(k);
            step();
            chk("sh_no_early_valid", 32'(valid_o), 32'd0);
        end
        valid_i = 1'b0;
        chk("sh_full_occ", 32'(occ), 32'd8);
        chk("sh_full_ready", 32'(ready_o), 32'd0);
        step();
        chk("sh_valid_after_full", 32'(valid_o), 32'd1);
        collect(got, n);
        chk("sh_count", 32'(n), 32'd8);
        seen = '0; in_order = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (got[k] >= 32'h20 && got[k] < 32'h28) seen[got[k][2:0]] = 1'b1;
            if (got[k] != 32'h20 + 32'(k)) in_order = 1'b0;
        end
        chk("sh_all_seen", 32'(seen), 32'hFF);
        chk("sh_reordered", 32'(in_order), 32'd0);
        chk("sh_empty", 32'(occ), 32'd0);

        // Same ID: order must be preserved.
        for (int k = 0; k < 8; k++) begin
            valid_i = 1'b1; id_i = 4'd3; data_i = 32'(k);
            step();
        end
        valid_i = 1'b0;
        collect(got, n);
        chk("sid_count", 32'(n), 32'd8);
        for (int k = 0; k < 8; k++) chk("sid_order", got[k], 32'(k));

        // Forced release after MaxHold.
        step();
        valid_i = 1'b1; id_i = 4'd5; data_i = 32'hAB;
        step();
        valid_i = 1'b0;
        first = 0;
        for (int k = 1; k <= 30 && first == 0; k++) begin
            step();
            if (valid_o) begin
                first = k;
                held_id = id_o;
                held_data = data_o;
            end
        end
        chk("hold_latency", 32'(first), 32'd17);
        chk("hold_id", 32'(held_id), 32'd5);
        chk("hold_data", held_data, 32'hAB);
        step(); step();
        chk("hold_empty", 32'(occ), 32'd0);

        // Backpressure: locked beat stays stable.
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            valid_i = 1'b1; id_i = 4'(k); data_i = 32'h40 + 32'(k);
            step();
        end
        valid_i = 1'b0;
        step();
        chk("bp_valid", 32'(valid_o), 32'd1);
        held_id = id_o; held_data = data_o;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid_hold", 32'(valid_o), 32'd1);
            chk("bp_id_stable", 32'(id_o), 32'(held_id));
            chk("bp_data_stable", data_o, held_data);
            chk("bp_ready_o", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        collect(got, n);
        chk("bp_count", 32'(n), 32'd8);
        seen = '0;
        for (int k = 0; k < n; k++)
            if (got[k] >= 32'h40 && got[k] < 32'h48) seen[got[k][2:0]] = 1'b1;
        chk("bp_all_seen", 32'(seen), 32'hFF);
        chk("bp_first_is_held", got[0], held_data);

        // Reset with residents discards them.
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1; id_i = 4'(k); data_i = 32'h60 + 32'(k);
            step();
        end
        valid_i = 1'b0;
        chk("rr_occ5", 32'(occ), 32'd5);
        chk("rr_valid_pre", 32'(valid_o), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rr_occ", 32'(occ), 32'd0);
        chk("rr_valid", 32'(valid_o), 32'd0);
        chk("rr_ready", 32'(ready_o), 32'd1);
        leaked = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (valid_o) leaked = 1'b1;
        end
        chk("rr_no_leak", 32'(leaked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
